game_timer_ctrl: RTL and testbench
==================================

Name: game_timer_ctrl

Overview:
- Sequencing controller for the chained BCD digit timer of the Sudoku game clock.
- Loads the per-digit defaults into the chain with a reconfigure pulse.
- Divides the system clock down to a one-second tick for the least-significant digit, and injects bursts of extra ticks as mistake penalties.
- Runs the start/pause/expire state machine, using the chain's terminal flag to detect time-out.

Parameters:
- CLKS_PER_TICK, 50000000: system clocks per one-second tick; must be ≥ 2.
- RECONF_CYCLES, 2: clocks that reconf is held high during a load.
- PENALTY_TICKS, 10: extra ticks queued per penalty pulse.
- PEND_W, 8: width of the pending-penalty counter.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- cfg_default  in  16  four BCD digits, [3:0] least significant; sampled on load.
- load  in  1  single-cycle request: latch cfg_default and reconfigure the chain.
- start  in  1  single-cycle request: begin or resume counting.
- pause  in  1  single-cycle request: suspend counting.
- penalty  in  1  single-cycle request: queue PENALTY_TICKS extra ticks.
- chain_done  in  1  terminal flag from the most-significant digit; asynchronous to clk.
- reconf  out  1  to every digit's reconf input.
- count_default  out  16  to the digits' count_default inputs; nibble i goes to digit i.
- tick  out  1  to the least-significant digit's borrow_dn input.
- running  out  1  high while in state RUN.
- expired  out  1  high in state EXPIRED.

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-low. On rst_n=0 at a clk edge:
  - state=IDLE;
  - reconf, tick, running and expired all 0;
  - count_default=0;
  - prescaler, reconf counter, pending counter and synchronizer flops cleared.
  - Reset mid-load or mid-run aborts immediately; no tick or reconf is emitted in the following cycle.
- All outputs are registered.
- Request priority in one cycle: load > pause > start > penalty. Requests not legal in the current state are ignored.
- chain_done passes through a 2-flop synchronizer to give done_s. The state reacts in the cycle after done_s is sampled high.
- States:
  - LOAD (entered from any state when load=1):
    - latch count_default<=cfg_default unmodified (digits handle values >9 themselves);
    - reconf=1 for exactly RECONF_CYCLES clocks, then return to IDLE with reconf=0;
    - prescaler and pending cleared, expired cleared;
    - start and penalty during LOAD are ignored.
  - IDLE: waits. start → RUN. penalty accumulates into pending.
  - RUN:
    - Prescaler counts 0..CLKS_PER_TICK-1. At the terminal count it wraps to 0 and tick=1 for one clock.
    - If pending>0 and no prescaler tick is due, a penalty tick is emitted and pending decrements.
    - Spacing rule: tick is never high on two consecutive clocks. A tick (prescaler or penalty) that would follow a tick cycle is deferred one clock. A deferred prescaler tick holds the prescaler at its terminal value.
    - On a prescaler/penalty collision the prescaler wins; the penalty tick goes next eligible cycle.
    - pause → PAUSE. done_s=1 → EXPIRED.
  - PAUSE:
    - tick=0. Prescaler value is retained, so the partial second resumes.
    - start → RUN. penalty accumulates.
    - done_s is ignored until RUN.
  - EXPIRED:
    - tick=0, expired=1, pending cleared.
    - start, pause and penalty are ignored. Only load or reset leaves this state.
- Pending counter:
  - pending += PENALTY_TICKS per penalty pulse, saturating at 2^PEND_W-1.
  - Penalty accepted in IDLE, PAUSE and RUN.
  - If a penalty pulse and a penalty-tick decrement coincide, the net is +PENALTY_TICKS-1.
- running = (state==RUN).

Test Plan:
1. Load: CLKS_PER_TICK=4, RECONF_CYCLES=2, cfg_default=16'h0305, load pulse → count_default=16'h0305 registered; reconf high exactly 2 clocks; state IDLE; tick stays 0.
2. Run: start after load, hold 20 clocks → tick pulses on clocks 4, 8, 12, 16, 20 after start, each 1 clock wide; running=1 throughout.
3. Pause/resume: start, run 6 clocks, pause for 10 clocks, then start → no ticks during pause; next tick 2 clocks after resume (prescaler retained).
4. Penalty: PENALTY_TICKS=3, penalty in RUN just before a prescaler terminal → prescaler tick first, then 3 penalty ticks, all separated by ≥1 low clock; pending returns to 0. With PEND_W=2, two penalties saturate pending at 3.
5. Expiry: in RUN raise chain_done → expired=1 and tick held 0 starting the 3rd clock after chain_done rises; start/penalty ignored; load clears expired and reconfigures.
6. Reset/priority: assert rst_n=0 mid-reconf → reconf=0 next edge and all outputs at reset values. load and pause in the same cycle as RUN → LOAD wins.

Source files
------------

// File: rtl/game_timer_ctrl.sv
// Sequencing controller for the BCD digit-chain game clock: loads digit
// defaults, generates the one-second tick plus penalty ticks, and tracks expiry.
module game_timer_ctrl #(
    parameter int CLKS_PER_TICK = 50000000,
    parameter int RECONF_CYCLES = 2,
    parameter int PENALTY_TICKS = 10,
    parameter int PEND_W        = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cfg_default,
    input  logic        load,
    input  logic        start,
    input  logic        pause,
    input  logic        penalty,
    input  logic        chain_done,
    output logic        reconf,
    output logic [15:0] count_default,
    output logic        tick,
    output logic        running,
    output logic        expired
);

    localparam int PW        = $clog2(CLKS_PER_TICK);
    localparam int RW        = (RECONF_CYCLES > 1) ? $clog2(RECONF_CYCLES) : 1;
    localparam int PEND_TOP  = (2 ** PEND_W) - 1;
    localparam int PEN_CLAMP = (PENALTY_TICKS > PEND_TOP) ? PEND_TOP : PENALTY_TICKS;

    localparam logic [PW-1:0]   TERM      = PW'(CLKS_PER_TICK - 1);
    localparam logic [RW-1:0]   RCNT_INIT = RW'(RECONF_CYCLES - 1);
    localparam logic [PEND_W:0] PEN_INC   = (PEND_W + 1)'(PEN_CLAMP);
    localparam logic [PEND_W:0] PEND_MAX  = (PEND_W + 1)'(PEND_TOP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_PAUSE,
        S_EXPIRED
    } state_t;

    state_t            state, state_n;
    logic [PW-1:0]     presc, presc_n;
    logic [RW-1:0]     rcnt, rcnt_n;
    logic [PEND_W-1:0] pending, pend_n, pend_base;
    logic [PEND_W:0]   pend_sum;
    logic [1:0]        sync_pipe;
    logic              done_s;
    logic              tick_n, reconf_n, pend_dec, pen_ok;
    logic [15:0]       cdef_n;

    assign done_s = sync_pipe[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            presc         <= '0;
            rcnt          <= '0;
            pending       <= '0;
            sync_pipe     <= '0;
            reconf        <= 1'b0;
            tick          <= 1'b0;
            running       <= 1'b0;
            expired       <= 1'b0;
            count_default <= '0;
        end else begin
            state         <= state_n;
            presc         <= presc_n;
            rcnt          <= rcnt_n;
            pending       <= pend_n;
            sync_pipe     <= {sync_pipe[0], chain_done};
            reconf        <= reconf_n;
            tick          <= tick_n;
            running       <= (state_n == S_RUN);
            expired       <= (state_n == S_EXPIRED);
            count_default <= cdef_n;
        end
    end

    always_comb begin
        state_n   = state;
        presc_n   = presc;
        rcnt_n    = rcnt;
        pend_n    = pending;
        cdef_n    = count_default;
        tick_n    = 1'b0;
        reconf_n  = 1'b0;
        pend_dec  = 1'b0;
        pen_ok    = 1'b0;
        pend_base = pending;
        pend_sum  = '0;

        if (load) begin
            state_n  = S_LOAD;
            rcnt_n   = RCNT_INIT;
            reconf_n = 1'b1;
            cdef_n   = cfg_default;
            presc_n  = '0;
            pend_n   = '0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (rcnt == '0) begin
                        state_n = S_IDLE;
                    end else begin
                        rcnt_n   = rcnt - RW'(1);
                        reconf_n = 1'b1;
                    end
                end
                S_IDLE, S_PAUSE: begin
                    if (start) state_n = S_RUN;
                    else       pen_ok  = 1'b1;
                end
                S_RUN: begin
                    if (done_s) begin
                        state_n = S_EXPIRED;
                        pend_n  = '0;
                    end else if (pause) begin
                        state_n = S_PAUSE;
                    end else begin
                        pen_ok = 1'b1;
                        // A terminal count right after a tick waits here, holding the prescaler.
                        if (presc == TERM) begin
                            if (!tick) begin
                                tick_n  = 1'b1;
                                presc_n = '0;
                            end
                        end else begin
                            presc_n = presc + PW'(1);
                            if (pending != '0 && !tick) begin
                                tick_n   = 1'b1;
                                pend_dec = 1'b1;
                            end
                        end
                    end
                end
                S_EXPIRED: pend_n = '0;
                default:   state_n = S_IDLE;
            endcase

            if (pen_ok) begin
                pend_base = pending - PEND_W'(pend_dec);
                pend_sum  = {1'b0, pend_base} + PEN_INC;
                if (!penalty)             pend_n = pend_base;
                else if (pend_sum > PEND_MAX) pend_n = PEND_MAX[PEND_W-1:0];
                else                      pend_n = pend_sum[PEND_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Scoreboard bench for game_timer_ctrl: stimulus pushes hand-derived per-cycle
// output vectors, a negedge monitor pops and compares them.
module tb_game_timer_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cfg_default;
    logic        load, start, pause, penalty, chain_done;
    logic        reconf, tick, running, expired;
    logic [15:0] count_default;

    int errors = 0;
    int checks = 0;
    int cyc_no = 0;
    logic [15:0] cd_e = '0;

    typedef struct packed {
        logic        reconf;
        logic        tick;
        logic        running;
        logic        expired;
        logic [15:0] cdef;
    } obs_t;

    obs_t exp_q[$];

    game_timer_ctrl #(
        .CLKS_PER_TICK(4),
        .RECONF_CYCLES(2),
        .PENALTY_TICKS(3),
        .PEND_W(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cfg_default(cfg_default),
        .load(load),
        .start(start),
        .pause(pause),
        .penalty(penalty),
        .chain_done(chain_done),
        .reconf(reconf),
        .count_default(count_default),
        .tick(tick),
        .running(running),
        .expired(expired)
    );

    always #5 clk = ~clk;

    // One clock: drive requests, then expect outputs as they stand after that edge.
    task automatic cyc(input logic ld, st, pa, pe, input logic rc, tk, rn, ex);
        load = ld; start = st; pause = pa; penalty = pe;
        @(posedge clk);
        exp_q.push_back({rc, tk, rn, ex, cd_e});
        #1;
        load = 1'b0; start = 1'b0; pause = 1'b0; penalty = 1'b0;
    endtask

    task automatic run_n(input int n, input logic [31:0] ticks, input logic rn);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ticks[i], rn, 1'b0);
    endtask

    initial begin : monitor
        obs_t e, got;
        forever begin
            @(negedge clk);
            cyc_no++;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {reconf, tick, running, expired, count_default};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL outputs@cycle%0d got rc=%b tk=%b rn=%b ex=%b cd=%h required rc=%b tk=%b rn=%b ex=%b cd=%h",
                             cyc_no, got.reconf, got.tick, got.running, got.expired, got.cdef,
                             e.reconf, e.tick, e.running, e.expired, e.cdef);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst_n = 1'b0; cfg_default = 16'hFFFF; chain_done = 1'b0;
        load = 1'b0; start = 1'b0; pause = 1'b0; penalty = 1'b0;

        // Reset, with a load request that reset must override
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        cyc(0, 0, 0, 0, 0, 0, 0, 0);

        // Load: reconf exactly two clocks, start/penalty ignored meanwhile
        cfg_default = 16'h0305; cd_e = 16'h0305;
        cyc(1, 0, 0, 0, 1, 0, 0, 0);
        cfg_default = 16'h1234;
        cyc(0, 1, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);

        // Run 20 clocks: ticks on clocks 4, 8, 12, 16, 20
        cyc(0, 1, 0, 0, 0, 0, 1, 0);
        run_n(20, 32'h0008_8888, 1'b1);

        // Pause/resume with prescaler retained (left at 2)
        run_n(6, 32'h08, 1'b1);
        cyc(0, 0, 1, 0, 0, 0, 0, 0);
        run_n(10, 32'h0, 1'b0);
        cyc(0, 1, 0, 0, 0, 0, 1, 0);
        run_n(5, 32'h2, 1'b1);

        // Penalty on a prescaler terminal: prescaler tick first, then three spaced
        cyc(0, 0, 0, 1, 0, 1, 1, 0);
        run_n(12, 32'hAAA, 1'b1);
        run_n(4, 32'h8, 1'b1);

        // Penalty tick lands just before terminal: prescaler tick deferred one clock
        run_n(1, 32'h0, 1'b1);
        cyc(0, 0, 0, 1, 0, 0, 1, 0);
        run_n(15, 32'h4555, 1'b1);

        // Two penalties while paused saturate pending at 3
        cyc(0, 0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 1, 0);
        run_n(13, 32'h1155, 1'b1);

        // Expiry: synchronizer latency, then requests ignored until load
        chain_done = 1'b1;
        run_n(2, 32'h0, 1'b1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 0, 0, 0, 1);
        cyc(0, 0, 1, 0, 0, 0, 0, 1);
        chain_done = 1'b0;
        cfg_default = 16'h0042; cd_e = 16'h0042;
        cyc(1, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 1, 0);
        run_n(4, 32'h8, 1'b1);

        // Load beats pause in RUN, then reset mid-reconf
        cfg_default = 16'h9876; cd_e = 16'h9876;
        cyc(1, 0, 1, 0, 1, 0, 0, 0);
        rst_n = 1'b0; cd_e = 16'h0000;
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 1, 0);
        run_n(4, 32'h8, 1'b1);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
